// File: rtl/reg_alu_pipe.sv
// reg_alu_pipe: two-stage register-file ALU pipeline.
// Stage 1 captures operands (with forwarding from the command in flight) and control.
// Stage 2 computes the write-back value, updates the register file, result and flags.
module reg_alu_pipe #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              sel,
  input  logic              wr,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  d_in,
  output logic [WIDTH-1:0]  d_out_a,
  output logic [WIDTH-1:0]  d_out_b,
  output logic [WIDTH-1:0]  result,
  output logic              out_valid,
  output logic              cout,
  output logic              zero
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0]  regs [DEPTH];

  logic              s1_valid;
  logic              s1_sel;
  logic              s1_wr;
  logic [2:0]        s1_op;
  logic [ADDR_W-1:0] s1_wr_addr;
  logic [WIDTH-1:0]  s1_a;
  logic [WIDTH-1:0]  s1_b;
  logic [WIDTH-1:0]  s1_d_in;

  logic [WIDTH-1:0]  alu_val;
  logic              alu_carry;
  logic [WIDTH:0]    sum_ext;
  logic [WIDTH-1:0]  wb_val;
  logic              fwd_a;
  logic              fwd_b;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;

  // ALU on the stage-1 operands; op 111 chains off the live carry register,
  // which already holds the carry of the command completing just before this one.
  always_comb begin
    sum_ext   = '0;
    alu_val   = '0;
    alu_carry = 1'b0;
    case (s1_op)
      3'b000: begin
        sum_ext   = {1'b0, s1_a} + {1'b0, s1_b};
        alu_val   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      3'b001: begin
        sum_ext   = {1'b0, s1_a} + {1'b0, ~s1_b} + {{WIDTH{1'b0}}, 1'b1};
        alu_val   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      3'b010: alu_val = s1_a & s1_b;
      3'b011: alu_val = s1_a | s1_b;
      3'b100: alu_val = s1_a ^ s1_b;
      3'b101: begin
        alu_val   = {s1_a[WIDTH-2:0], 1'b0};
        alu_carry = s1_a[WIDTH-1];
      end
      3'b110: begin
        alu_val   = {1'b0, s1_a[WIDTH-1:1]};
        alu_carry = s1_a[0];
      end
      default: begin
        sum_ext   = {1'b0, s1_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, cout};
        alu_val   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
    endcase
  end

  // Write-back selection and operand forwarding from the command held in stage 1.
  always_comb begin
    wb_val = s1_sel ? alu_val : s1_d_in;
    fwd_a  = s1_valid && s1_wr && (s1_wr_addr == rd_addr_a);
    fwd_b  = s1_valid && s1_wr && (s1_wr_addr == rd_addr_b);
    op_a   = fwd_a ? wb_val : regs[rd_addr_a];
    op_b   = fwd_b ? wb_val : regs[rd_addr_b];
  end

  assign d_out_a = regs[rd_addr_a];
  assign d_out_b = regs[rd_addr_b];

  // Stage 1: capture the issued command; reset discards anything pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_sel     <= 1'b0;
      s1_wr      <= 1'b0;
      s1_op      <= '0;
      s1_wr_addr <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_d_in    <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sel     <= sel;
        s1_wr      <= wr;
        s1_op      <= op;
        s1_wr_addr <= wr_addr;
        s1_a       <= op_a;
        s1_b       <= op_b;
        s1_d_in    <= d_in;
      end
    end
  end

  // Stage 2: complete the command - register write, result, flags, completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      result    <= '0;
      out_valid <= 1'b0;
      cout      <= 1'b0;
      zero      <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= wb_val;
        zero   <= (wb_val == '0);
        if (s1_sel) cout <= alu_carry;
        if (s1_wr) regs[s1_wr_addr] <= wb_val;
      end
    end
  end

endmodule

// File: tb/tb_reg_alu_pipe.sv
// tb_reg_alu_pipe: directed vectors with hand-computed expectations for reg_alu_pipe.
module tb_reg_alu_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        sel = 1'b0;
  logic        wr = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [2:0]  rd_addr_a = '0;
  logic [2:0]  rd_addr_b = '0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] d_in = '0;
  logic [15:0] d_out_a;
  logic [15:0] d_out_b;
  logic [15:0] result;
  logic        out_valid;
  logic        cout;
  logic        zero;

  int checks = 0;
  int errors = 0;

  reg_alu_pipe #(.WIDTH(16), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sel(sel), .wr(wr), .op(op),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr), .d_in(d_in),
    .d_out_a(d_out_a), .d_out_b(d_out_b), .result(result),
    .out_valid(out_valid), .cout(cout), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one command, clock one edge, leave the inputs applied.
  task automatic issue(input logic s, input logic w, input logic [2:0] o,
                       input logic [2:0] ra, input logic [2:0] rb,
                       input logic [2:0] wa, input logic [15:0] d);
    sel = s; wr = w; op = o; rd_addr_a = ra; rd_addr_b = rb; wr_addr = wa; d_in = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic read_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
    rd_addr_a = a; rd_addr_b = a;
    #1;
    check({tag, "_a"}, d_out_a, exp);
    check({tag, "_b"}, d_out_b, exp);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_zero", zero, 0);
    reset = 1'b0;

    // Immediate write r3=cdef
    issue(0, 1, 3'b000, 0, 0, 3, 16'hcdef);
    check("imm_no_early_valid", out_valid, 0);
    idle();
    check("imm_valid", out_valid, 1);
    check("imm_result", result, 16'hcdef);
    check("imm_zero", zero, 0);
    read_reg("imm_r3", 3, 16'hcdef);
    idle();
    check("imm_valid_drop", out_valid, 0);

    // r7=3210, r2=0001, then add / add-to-zero / adc chain back to back
    issue(0, 1, 3'b000, 0, 0, 7, 16'h3210);
    issue(0, 1, 3'b000, 0, 0, 2, 16'h0001);
    idle(); idle();
    issue(1, 1, 3'b000, 3, 7, 1, 16'h0000);
    issue(1, 1, 3'b000, 1, 2, 4, 16'h0000);
    check("add_result", result, 16'hffff);
    check("add_cout", cout, 0);
    issue(1, 0, 3'b111, 0, 0, 0, 16'h0000);
    check("add0_result", result, 16'h0000);
    check("add0_cout", cout, 1);
    check("add0_zero", zero, 1);
    idle();
    check("adc_result", result, 16'h0001);
    check("adc_cout", cout, 0);
    check("adc_zero", zero, 0);
    read_reg("add_r1", 1, 16'hffff);
    read_reg("adc_r0_unchanged", 0, 16'h0000);

    // Forwarding: r5=4567 then r6=r5+r5
    issue(0, 1, 3'b000, 0, 0, 5, 16'h4567);
    issue(1, 1, 3'b000, 5, 5, 6, 16'h0000);
    check("fwd_valid1", out_valid, 1);
    check("fwd_result1", result, 16'h4567);
    idle();
    check("fwd_valid2", out_valid, 1);
    check("fwd_result2", result, 16'h8ace);
    check("fwd_cout", cout, 0);
    read_reg("fwd_r6", 6, 16'h8ace);
    idle();
    check("fwd_valid_drop", out_valid, 0);

    // Sub, shifts and logic ops, all wr=0
    issue(1, 0, 3'b001, 7, 3, 7, 16'h0000);
    issue(1, 0, 3'b101, 3, 0, 7, 16'h0000);
    check("sub_result", result, 16'h6421);
    check("sub_cout", cout, 0);
    issue(1, 0, 3'b010, 3, 7, 7, 16'h0000);
    check("shl_result", result, 16'h9bde);
    check("shl_cout", cout, 1);
    issue(1, 0, 3'b110, 3, 0, 7, 16'h0000);
    check("and_result", result, 16'h0000);
    check("and_zero", zero, 1);
    check("and_cout", cout, 0);
    issue(1, 0, 3'b100, 3, 7, 7, 16'h0000);
    check("shr_result", result, 16'h66f7);
    check("shr_cout", cout, 1);
    issue(1, 0, 3'b011, 3, 7, 7, 16'h0000);
    check("xor_result", result, 16'hffff);
    check("xor_cout", cout, 0);
    issue(1, 0, 3'b101, 3, 0, 7, 16'h0000);
    check("or_result", result, 16'hffff);
    idle();
    check("shl2_cout", cout, 1);
    read_reg("wr0_r7_kept", 7, 16'h3210);

    // sel=0 leaves cout alone, zero follows d_in; consecutive writes to one address
    issue(0, 1, 3'b000, 0, 0, 4, 16'h0000);
    issue(0, 1, 3'b000, 0, 0, 4, 16'h1111);
    check("sel0_zero", zero, 1);
    check("sel0_cout_held", cout, 1);
    issue(0, 1, 3'b000, 0, 0, 4, 16'h2222);
    idle();
    idle();
    read_reg("same_addr_r4", 4, 16'h2222);

    // Reset discards the command in stage 1
    issue(0, 1, 3'b000, 0, 0, 2, 16'h1234);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_kill_valid", out_valid, 0);
    check("rst_kill_cout", cout, 0);
    reset = 1'b0;
    read_reg("rst_kill_r2", 2, 16'h0000);
    idle();
    check("rst_kill_no_pulse", out_valid, 0);
    read_reg("rst_clears_r6", 6, 16'h0000);

    // Reset overrides in_valid at the same edge
    sel = 0; wr = 1; wr_addr = 3; d_in = 16'h5a5a; in_valid = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    check("rst_override_valid", out_valid, 0);
    read_reg("rst_override_r3", 3, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_alu_pipe.md
REG_ALU_PIPE -- requirements
Module: reg_alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16: register and datapath width in bits, legal range 4..64.
REQ-002 Parameter ADDR_W, default 3: register address width; DEPTH = 2**ADDR_W registers.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  issues the command on the current inputs at the next edge.
REQ-006 sel  input  1  0: write-back value is d_in; 1: write-back value is the ALU result.
REQ-007 wr  input  1  1: write back to register wr_addr; 0: no register write.
REQ-008 op  input  3  ALU operation (see REQ-015).
REQ-009 rd_addr_a, rd_addr_b  input  ADDR_W each  operand A and operand B register addresses.
REQ-010 wr_addr  input  ADDR_W  write-back register address.
REQ-011 d_in  input  WIDTH  immediate write data.
REQ-012 d_out_a, d_out_b  output  WIDTH each  combinational reads of registers rd_addr_a and rd_addr_b, no bypass.
REQ-013 result  output  WIDTH  registered write-back value of the last completed command.
REQ-014 out_valid, cout, zero  output  1 each  completion pulse, carry flag register, result==0 flag.

Function
REQ-015 Ops, with A and B the operands: 000 A+B; 001 A-B computed as A+~B+1; 010 A&B; 011 A|B; 100 A^B; 101 A<<1; 110 A>>1 logical; 111 A+B+cout.
REQ-016 Pipeline stage 1: when in_valid=1 at edge N, the block SHALL capture operands, op, sel, wr, wr_addr and d_in, and set s1_valid.
REQ-017 Pipeline stage 2: at edge N+1, if s1_valid is set, the block SHALL write the register (if wr=1) and load result, and SHALL pulse out_valid high for exactly the cycle after edge N+1.
REQ-018 The block SHALL accept one command per cycle with no stalls; out_valid SHALL be low in every cycle with no completion.
REQ-019 Forwarding: if stage 1 holds a command with wr=1 whose wr_addr equals the rd_addr being captured at an edge, the captured operand SHALL be that command's write-back value, not the stale register contents.
REQ-020 cout SHALL update only on completion with sel=1:
- add, adc: carry out of the MSB.
- sub: carry out of A+~B+1, i.e. 1 means no borrow.
- shl: A[WIDTH-1].
- shr: A[0].
- logic ops: 0.
REQ-021 Op 111 SHALL use the cout value registered at the edge on which stage 2 completes the preceding command, so back-to-back carry chaining is exact.
REQ-022 zero SHALL load (write-back value == 0) on every completion, including sel=0.
REQ-023 Arithmetic SHALL be modulo 2**WIDTH.
REQ-024 Register 0 is an ordinary writable register.
REQ-025 With wr=0, result, zero and cout still update per REQ-020/022 and no register changes.
REQ-026 A command issued with wr=1 to the same wr_addr in consecutive cycles SHALL leave the later value in the register.

Reset
REQ-027 When reset is high at an edge: all DEPTH registers <= 0, s1_valid <= 0, result <= 0, out_valid <= 0, cout <= 0, zero <= 0.
REQ-028 Reset SHALL override in_valid at the same edge, and a command held in stage 1 SHALL be discarded with no register write and no out_valid pulse.

Verification (WIDTH=16, ADDR_W=3)
REQ-029 Reset, then issue sel=0 wr=1 wr_addr=3 d_in=cdef -> out_valid pulses one cycle later, result=cdef, zero=0, d_out_a=cdef with rd_addr_a=3.
REQ-030 Registers r3=cdef, r7=3210; issue op=000 A=r3 B=r7 sel=1 wr_addr=1 -> r1=ffff, cout=0; then op=000 A=r1 B=r2 (r2=0001) -> result=0000, cout=1, zero=1; then op=111 A=r0 B=r0 (both 0) -> result=0001, cout=0.
REQ-031 Issue sel=0 wr=1 wr_addr=5 d_in=4567, next cycle op=000 A=r5 B=r5 sel=1 wr_addr=6 -> forwarding gives r6=8ace, cout=0, two consecutive out_valid pulses.
REQ-032 r7=3210, r3=cdef; op=001 A=r7 B=r3 -> result=6421, cout=0; op=101 A=r3 (cdef) -> result=9bde, cout=1.
REQ-033 Issue sel=0 wr=1 wr_addr=2 d_in=1234 and assert reset on the following edge -> r2 reads 0000, out_valid never pulses, cout=0.
